// File: rtl/mult_div_unit.sv
// Multi-cycle multiply/divide unit holding HI/LO.
// Operands are latched at start; the result is committed after a fixed cycle count.
module mult_div_unit #(
    parameter int unsigned MULT_CYCLES = 5,
    parameter int unsigned DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  op,
    input  logic [31:0] A,
    input  logic [31:0] B,
    output logic        busy,
    output logic        done,
    output logic [31:0] HI,
    output logic [31:0] LO
);

    localparam int unsigned MaxCycles = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int unsigned CntW      = $clog2(MaxCycles + 1);

    typedef enum logic {StIdle, StBusy} state_e;

    state_e            state_q;
    logic [CntW-1:0]   cnt_q;
    logic [1:0]        op_q;
    logic [31:0]       a_q;
    logic [31:0]       b_q;
    logic              done_q;
    logic [31:0]       hi_q;
    logic [31:0]       lo_q;

    logic [63:0]       prod_s;
    logic [63:0]       prod_u;
    logic [31:0]       quot_s;
    logic [31:0]       rem_s;
    logic [31:0]       quot_u;
    logic [31:0]       rem_u;
    logic              div_by_zero;
    logic              div_ovf;
    logic              commit_ok;
    logic [31:0]       res_hi;
    logic [31:0]       res_lo;

    // Result is formed from the latched operands only, so HI/LO never see A/B directly.
    always_comb begin
        prod_s      = $signed({{32{a_q[31]}}, a_q}) * $signed({{32{b_q[31]}}, b_q});
        prod_u      = {32'b0, a_q} * {32'b0, b_q};
        div_by_zero = (b_q == 32'h0);
        div_ovf     = (a_q == 32'h8000_0000) && (b_q == 32'hFFFF_FFFF);
        quot_s      = '0;
        rem_s       = '0;
        quot_u      = '0;
        rem_u       = '0;
        if (div_ovf) begin
            quot_s = a_q;
        end else if (!div_by_zero) begin
            quot_s = $signed(a_q) / $signed(b_q);
            rem_s  = $signed(a_q) % $signed(b_q);
        end
        if (!div_by_zero) begin
            quot_u = a_q / b_q;
            rem_u  = a_q % b_q;
        end
        res_hi = '0;
        res_lo = '0;
        unique case (op_q)
            2'd0: {res_hi, res_lo} = prod_s;
            2'd1: {res_hi, res_lo} = prod_u;
            2'd2: begin
                res_hi = rem_s;
                res_lo = quot_s;
            end
            2'd3: begin
                res_hi = rem_u;
                res_lo = quot_u;
            end
            default: ;
        endcase
        commit_ok = !(op_q[1] && div_by_zero);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            op_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
            done_q  <= 1'b0;
            hi_q    <= '0;
            lo_q    <= '0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (start) begin
                        case (op)
                            3'd0, 3'd1, 3'd2, 3'd3: begin
                                state_q <= StBusy;
                                op_q    <= op[1:0];
                                a_q     <= A;
                                b_q     <= B;
                                cnt_q   <= op[1] ? CntW'(DIV_CYCLES) : CntW'(MULT_CYCLES);
                            end
                            3'd4:    hi_q <= A;
                            3'd5:    lo_q <= A;
                            default: ;
                        endcase
                    end
                end
                StBusy: begin
                    cnt_q <= cnt_q - 1'b1;
                    if (cnt_q == CntW'(1)) begin
                        state_q <= StIdle;
                        done_q  <= 1'b1;
                        if (commit_ok) begin
                            hi_q <= res_hi;
                            lo_q <= res_lo;
                        end
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign busy = (state_q == StBusy);
    assign done = done_q;
    assign HI   = hi_q;
    assign LO   = lo_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// Directed plus randomized checks of mult_div_unit against a plain-arithmetic HI/LO model.
module tb_mult_div_unit;

    localparam int unsigned MultCycles = 5;
    localparam int unsigned DivCycles  = 10;

    logic        clk;
    logic        reset;
    logic        start;
    logic [2:0]  op;
    logic [31:0] A;
    logic [31:0] B;
    logic        busy;
    logic        done;
    logic [31:0] HI;
    logic [31:0] LO;

    int n_assert = 0;
    int n_fail   = 0;

    logic [31:0] m_hi = '0;
    logic [31:0] m_lo = '0;

    mult_div_unit #(
        .MULT_CYCLES (MultCycles),
        .DIV_CYCLES  (DivCycles)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .op    (op),
        .A     (A),
        .B     (B),
        .busy  (busy),
        .done  (done),
        .HI    (HI),
        .LO    (LO)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_state(input string tag, input logic eb, input logic ed,
                             input logic [31:0] eh, input logic [31:0] el);
        chk({tag, ".busy"}, {31'b0, busy}, {31'b0, eb});
        chk({tag, ".done"}, {31'b0, done}, {31'b0, ed});
        chk({tag, ".hi"}, HI, eh);
        chk({tag, ".lo"}, LO, el);
    endtask

    // Reference: 64-bit integer arithmetic straight from the ISA definitions.
    function automatic void model(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                                  output bit wr, output logic [31:0] h, output logic [31:0] l);
        longint          sa = longint'($signed(a));
        longint          sb = longint'($signed(b));
        longint unsigned ua = longint'(a);
        longint unsigned ub = longint'(b);
        longint          p;
        longint          q;
        longint          r;
        wr = 1'b1;
        h  = '0;
        l  = '0;
        case (o)
            3'd0: p = sa * sb;
            3'd1: p = longint'(ua * ub);
            3'd2: begin
                if (b == 0) wr = 1'b0;
                else begin
                    q = sa / sb;
                    r = sa % sb;
                    p = {r[31:0], q[31:0]};
                end
            end
            default: begin
                if (b == 0) wr = 1'b0;
                else p = longint'({32'(ua % ub), 32'(ua / ub)});
            end
        endcase
        if (wr) begin
            h = p[63:32];
            l = p[31:0];
        end
    endfunction

    // Issue one op; optionally inject a (must-be-ignored) start at busy sample k == inj_k.
    task automatic run_op(input string tag, input logic [2:0] o, input logic [31:0] a,
                          input logic [31:0] b, input int inj_k, input logic [2:0] io,
                          input logic [31:0] ia, input logic [31:0] ib, input bit settle);
        bit          wr;
        logic [31:0] eh;
        logic [31:0] el;
        int          n;
        start = 1'b1;
        op    = o;
        A     = a;
        B     = b;
        if (o >= 3'd4) begin
            step();
            start = 1'b0;
            if (o == 3'd4) m_hi = a;
            if (o == 3'd5) m_lo = a;
            chk_state({tag, ".mt"}, 1'b0, 1'b0, m_hi, m_lo);
            return;
        end
        model(o, a, b, wr, eh, el);
        n = o[1] ? DivCycles : MultCycles;
        for (int k = 0; k < n; k++) begin
            step();
            chk_state({tag, ".run"}, 1'b1, 1'b0, m_hi, m_lo);
            if (k == inj_k) begin
                start = 1'b1;
                op    = io;
                A     = ia;
                B     = ib;
            end else begin
                start = 1'b0;
                op    = 3'($urandom);
                A     = $urandom;
                B     = $urandom;
            end
        end
        step();
        start = 1'b0;
        if (wr) begin
            m_hi = eh;
            m_lo = el;
        end
        chk_state({tag, ".commit"}, 1'b0, 1'b1, m_hi, m_lo);
        if (settle) begin
            step();
            chk_state({tag, ".after"}, 1'b0, 1'b0, m_hi, m_lo);
        end
    endtask

    initial begin
        logic [2:0]  ro;
        logic [31:0] ra;
        logic [31:0] rb;
        int          sel;
        reset = 1'b0;
        start = 1'b0;
        op    = '0;
        A     = '0;
        B     = '0;
        step();
        step();
        chk_state("reset", 1'b0, 1'b0, 32'h0, 32'h0);
        reset = 1'b1;
        step();

        run_op("mult", 3'd0, 32'hFFFF_FFFD, 32'd5, -1, 3'd0, 0, 0, 1'b1);
        chk("mult.hi_const", HI, 32'hFFFF_FFFF);
        chk("mult.lo_const", LO, 32'hFFFF_FFF1);
        run_op("multu", 3'd1, 32'hFFFF_FFFF, 32'd2, -1, 3'd0, 0, 0, 1'b1);
        chk("multu.hi_const", HI, 32'h0000_0001);
        chk("multu.lo_const", LO, 32'hFFFF_FFFE);
        run_op("div", 3'd2, 32'hFFFF_FFF9, 32'd2, -1, 3'd0, 0, 0, 1'b1);
        chk("div.hi_const", HI, 32'hFFFF_FFFF);
        chk("div.lo_const", LO, 32'hFFFF_FFFD);
        run_op("divu0", 3'd3, 32'd7, 32'd0, -1, 3'd0, 0, 0, 1'b1);
        chk("divu0.hi_const", HI, 32'hFFFF_FFFF);
        run_op("mthi", 3'd4, 32'h1234_5678, 32'd0, -1, 3'd0, 0, 0, 1'b1);
        chk("mthi.hi_const", HI, 32'h1234_5678);
        run_op("mtlo_busy", 3'd1, 32'd3, 32'd4, 1, 3'd5, 32'hDEAD_BEEF, 0, 1'b1);
        run_op("ovf", 3'd2, 32'h8000_0000, 32'hFFFF_FFFF, -1, 3'd0, 0, 0, 1'b1);
        chk("ovf.lo_const", LO, 32'h8000_0000);
        chk("ovf.hi_const", HI, 32'h0);
        run_op("ign", 3'd0, 32'd6, 32'd7, 1, 3'd3, 32'd9, 32'd4, 1'b0);
        run_op("b2b", 3'd3, 32'd9, 32'd4, DivCycles - 1, 3'd0, 32'd1, 32'd1, 1'b1);
        chk("b2b.lo_const", LO, 32'd2);
        chk("b2b.hi_const", HI, 32'd1);

        for (int i = 0; i < 40; i++) begin
            ro  = 3'($urandom_range(0, 7));
            ra  = $urandom;
            rb  = $urandom;
            sel = $urandom_range(0, 9);
            if (sel == 0) rb = 32'h0;
            if (sel == 1) begin
                ra = 32'h8000_0000;
                rb = 32'hFFFF_FFFF;
            end
            if (sel == 2) rb = 32'($urandom_range(1, 16));
            if (sel == 3) rb = -32'($urandom_range(1, 16));
            run_op("rand", ro, ra, rb, $urandom_range(0, 12) - 2, 3'($urandom), $urandom,
                   $urandom, 1'($urandom));
        end
        step();

        // Asynchronous reset mid-divide: everything clears between edges, no late commit.
        start = 1'b1;
        op    = 3'd2;
        A     = 32'd100;
        B     = 32'd7;
        step();
        start = 1'b0;
        step();
        step();
        step();
        #2 reset = 1'b0;
        #1;
        chk_state("arst", 1'b0, 1'b0, 32'h0, 32'h0);
        m_hi = '0;
        m_lo = '0;
        step();
        #2 reset = 1'b1;
        for (int k = 0; k < DivCycles + 2; k++) begin
            step();
            chk_state("arst.post", 1'b0, 1'b0, m_hi, m_lo);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
